// File: rtl/spi_tx_sched.sv
// spi_tx_sched: round-robin owner of the shared SPI TX FIFO, framing each packet with CS setup/hold
// and pacing SCLK through tx_clk_en.
module spi_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int CLK_DIV     = 4,
  parameter int SETUP_TICKS = 2,
  parameter int HOLD_TICKS  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_clk_en,
  output logic                       tx_wen,
  output logic [7:0]                 tx_wdata,
  input  logic [4:0]                 tx_rptr,
  input  logic [4:0]                 tx_wptr,
  output logic [NUM_REQ-1:0]         cs_n,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, SETUP, STREAM, DRAIN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d, rr_q, rr_d, pick;
  logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
  logic [DW-1:0]      div_q, div_d;
  logic [7:0]         tick_q, tick_d;
  logic [4:0]         occ;
  logic               full, empty;

  // Pointers are 5 bits over a 16-deep FIFO, so the difference wraps cleanly
  assign occ   = tx_wptr - tx_rptr;
  assign full  = occ == 5'd16;
  assign empty = occ == 5'd0;

  assign tx_clk_en = div_q == DW'(CLK_DIV - 1);
  assign busy      = state_q != IDLE;
  assign grant_id  = grant_q;
  assign cs_n      = cs_n_q;
  assign tx_wen    = state_q == STREAM && req_valid[grant_q] && !full;
  assign tx_wdata  = state_q == STREAM ? req_data[8*grant_q +: 8] : 8'd0;
  assign req_ready = (state_q == STREAM && !full) ? NUM_REQ'(1) << grant_q : '0;

  // Descending scan so the nearest valid requester at or after rr wins
  always_comb begin
    pick = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_q) + k) % NUM_REQ]) pick = IW'((int'(rr_q) + k) % NUM_REQ);
  end

  always_comb div_d = (state_q == IDLE || tx_clk_en) ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cs_n_d  = cs_n_q;
    tick_d  = tx_clk_en ? tick_q + 8'd1 : tick_q;
    case (state_q)
      IDLE:
        if (|req_valid) begin
          state_d = SETUP;
          grant_d = pick;
          cs_n_d  = ~(NUM_REQ'(1) << pick);
          tick_d  = '0;
        end
      SETUP:  state_d = int'(tick_d) >= SETUP_TICKS ? STREAM : SETUP;
      STREAM: state_d = (tx_wen && req_last[grant_q]) ? DRAIN : STREAM;
      DRAIN:
        if (empty) begin
          state_d = HOLD;
          tick_d  = '0;
        end
      HOLD:
        if (int'(tick_d) >= HOLD_TICKS) begin
          state_d = IDLE;
          cs_n_d  = '1;
          rr_d    = IW'((int'(grant_q) + 1) % NUM_REQ);
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cs_n_q  <= '1;
      div_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cs_n_q  <= cs_n_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end
endmodule

// File: tb/tb_spi_tx_sched.sv
// tb_spi_tx_sched: directed and randomized stimulus checked every cycle against a behavioural model
// of packet ownership, SCLK pacing and FIFO occupancy.
module tb_spi_tx_sched;
  localparam int N = 4, CD = 4, ST = 2, HT = 2;
  localparam int P_IDLE = 0, P_SETUP = 1, P_STREAM = 2, P_DRAIN = 3, P_HOLD = 4;

  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready, cs_n;
  logic [8*N-1:0] req_data = '0;
  logic           tx_clk_en, tx_wen, busy;
  logic [7:0]     tx_wdata;
  logic [4:0]     tx_rptr = '0, tx_wptr = '0;
  logic [1:0]     grant_id;

  spi_tx_sched #(.NUM_REQ(N), .CLK_DIV(CD), .SETUP_TICKS(ST), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_clk_en(tx_clk_en), .tx_wen(tx_wen), .tx_wdata(tx_wdata),
    .tx_rptr(tx_rptr), .tx_wptr(tx_wptr), .cs_n(cs_n), .grant_id(grant_id), .busy(busy));

  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  logic [8:0] pq [N][$];
  logic [7:0] wlog [$];
  int         dgr [$];
  logic [N-1:0] hs_s = '0, stall = '0;
  logic       wen_s = 1'b0, busy_p = 1'b0, ptr_hold = 1'b0;
  int         rd_mode = 0;

  bit           m_busy = 1'b0;
  int           m_own = 0, m_rr = 0, m_ph = P_IDLE, m_cnt = 0, m_cyc = 0;
  logic [4:0]   m_occ;
  logic         e_en, e_wen;
  logic [N-1:0] e_cs, e_rdy;

  task automatic chk(string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(int r, logic [7:0] d, bit l);
    pq[r].push_back({l, d});
  endtask

  task automatic rand_pkt(int r);
    int len = $urandom_range(1, 5);
    for (int i = 0; i < len; i++) push(r, 8'($urandom), i == len - 1);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pq[i].size() > 0 && !stall[i];
      req_data[8*i +: 8] = req_valid[i] ? pq[i][0][7:0] : 8'($urandom);
      req_last[i] = req_valid[i] ? pq[i][0][8] : 1'($urandom);
    end
  endtask

  // One clock: retire accepted bytes, move the transmitter's FIFO pointers, re-drive requesters
  task automatic cyc();
    logic [4:0] o;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    o = tx_wptr - tx_rptr;
    if (!ptr_hold) begin
      if (wen_s) tx_wptr = tx_wptr + 5'd1;
      if (o != 0 && (rd_mode == 2 || (rd_mode == 1 && $urandom_range(0, 1) == 1))) tx_rptr = tx_rptr + 5'd1;
    end
    drive();
    #1;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while ((busy || pending()) && k < 5000) begin
      cyc();
      k++;
    end
    chk("idle_timeout", k < 5000, 1);
  endtask

  // Model: a transaction is a grant followed by pulse-counted setup, a byte stream, a drain and
  // a pulse-counted hold; SCLK pulses fall on every CD-th cycle counted from the grant.
  always @(negedge clk) begin
    hs_s  = req_valid & req_ready;
    wen_s = tx_wen;
    if (tx_wen) wlog.push_back(tx_wdata);
    if (busy && !busy_p) dgr.push_back(int'(grant_id));
    busy_p = busy;
    if (rst) begin
      m_busy = 1'b0;
      m_rr   = 0;
      m_ph   = P_IDLE;
      chk("rst_cs_n", cs_n, 4'hF);
      chk("rst_busy", busy, 0);
      chk("rst_wen", tx_wen, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_clk_en", tx_clk_en, 0);
      chk("rst_wdata", tx_wdata, 0);
      chk("rst_grant", grant_id, 0);
    end else begin
      m_occ = tx_wptr - tx_rptr;
      e_en  = m_busy && (m_cyc % CD == CD - 1);
      e_cs  = m_busy ? ~(N'(1) << m_own) : 4'hF;
      e_wen = m_ph == P_STREAM && req_valid[m_own] && m_occ != 16;
      e_rdy = (m_ph == P_STREAM && m_occ != 16) ? N'(1) << m_own : '0;
      chk("busy", busy, m_busy);
      chk("cs_n", cs_n, e_cs);
      chk("clk_en", tx_clk_en, e_en);
      chk("wen", tx_wen, e_wen);
      chk("ready", req_ready, e_rdy);
      if (m_busy) chk("grant_id", grant_id, m_own);
      if (e_wen) chk("wdata", tx_wdata, req_data[8*m_own +: 8]);
      if (!m_busy) begin
        for (int k = 0; k < N; k++)
          if (req_valid[(m_rr + k) % N]) begin
            m_own  = (m_rr + k) % N;
            m_busy = 1'b1;
            m_ph   = P_SETUP;
            m_cnt  = 0;
            m_cyc  = 0;
            break;
          end
      end else begin
        if (m_ph == P_SETUP && e_en) begin
          m_cnt++;
          if (m_cnt == ST) m_ph = P_STREAM;
        end else if (m_ph == P_STREAM && e_wen && req_last[m_own]) begin
          m_ph = P_DRAIN;
        end else if (m_ph == P_DRAIN && m_occ == 0) begin
          m_ph  = P_HOLD;
          m_cnt = 0;
        end else if (m_ph == P_HOLD && e_en) begin
          m_cnt++;
          if (m_cnt == HT) begin
            m_busy = 1'b0;
            m_ph   = P_IDLE;
            m_rr   = (m_own + 1) % N;
          end
        end
        m_cyc++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, r;
    int arb_exp [4];
    arb_exp = '{0, 2, 3, 0};
    drive();
    cyc();
    cyc();
    rst = 1'b0;

    // single packet on req0 with a transmitter that drains every cycle
    rd_mode = 2;
    wlog.delete();
    push(0, 8'hA5, 0); push(0, 8'h3C, 0); push(0, 8'hFF, 1);
    drive();
    k = 0;
    while (cs_n == 4'hF && k < 20) begin cyc(); k++; end
    chk("sp_cs", cs_n, 4'hE);
    k = 0;
    while (!tx_wen && k < 40) begin cyc(); k++; end
    chk("sp_setup_lat", k, 8);
    wait_idle();
    chk("sp_nwr", wlog.size(), 3);
    if (wlog.size() == 3) chk("sp_bytes", {wlog[0], wlog[1], wlog[2]}, 24'hA53CFF);

    // backpressure: 20 bytes on req1, no reads until the FIFO is full
    rd_mode = 0;
    wlog.delete();
    for (int i = 0; i < 20; i++) push(1, 8'(i * 7 + 1), i == 19);
    drive();
    k = 0;
    while (5'(tx_wptr - tx_rptr) != 5'd16 && k < 100) begin cyc(); k++; end
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready", req_ready, 0);
      chk("bp_wen", tx_wen, 0);
      cyc();
    end
    chk("bp_nwr_full", wlog.size(), 16);
    rd_mode = 1;
    wait_idle();
    chk("bp_nwr_total", wlog.size(), 20);

    // arbitration: a req3 packet returns rr to 0, then req0/2/3 contend
    push(3, 8'h33, 1);
    drive();
    wait_idle();
    dgr.delete();
    rand_pkt(0); rand_pkt(2); rand_pkt(3); rand_pkt(0);
    drive();
    wait_idle();
    chk("arb_n", dgr.size(), 4);
    if (dgr.size() == 4) for (int i = 0; i < 4; i++) chk("arb_order", dgr[i], arb_exp[i]);

    // pointer wrap: 3-19 is full, 2-30 holds four bytes
    rd_mode = 0;
    for (int i = 0; i < 8; i++) push(1, 8'($urandom), i == 7);
    drive();
    k = 0;
    while (!tx_wen && k < 40) begin cyc(); k++; end
    ptr_hold = 1'b1;
    tx_wptr = 5'd3;
    tx_rptr = 5'd19;
    #1;
    chk("wrap_full_ready", req_ready, 0);
    chk("wrap_full_wen", tx_wen, 0);
    cyc();
    chk("wrap_full_busy", busy, 1);
    chk("wrap_full_wen2", tx_wen, 0);
    tx_wptr = 5'd2;
    tx_rptr = 5'd30;
    #1;
    chk("wrap_ok_ready", req_ready, 4'b0010);
    chk("wrap_ok_wen", tx_wen, 1);
    ptr_hold = 1'b0;
    rd_mode = 1;
    wait_idle();

    // stall: req2 goes quiet for 50 clk after two bytes
    wlog.delete();
    for (int i = 0; i < 6; i++) push(2, 8'($urandom), i == 5);
    drive();
    k = 0;
    while (wlog.size() < 2 && k < 60) begin cyc(); k++; end
    stall[2] = 1'b1;
    drive();
    #1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("stall_busy", busy, 1);
      chk("stall_cs", cs_n, 4'b1011);
      chk("stall_wen", tx_wen, 0);
    end
    stall[2] = 1'b0;
    drive();
    wait_idle();
    chk("stall_nwr", wlog.size(), 6);

    // random traffic with random stalls and reads
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, N - 1);
        if (pq[r].size() < 12) rand_pkt(r);
      end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 29) == 0) stall[i] = ~stall[i];
      drive();
      cyc();
    end
    stall = '0;
    drive();
    wait_idle();

    // asynchronous reset in the middle of a req0 stream
    rd_mode = 0;
    for (int i = 0; i < 10; i++) push(0, 8'($urandom), i == 9);
    drive();
    k = 0;
    while (!tx_wen && k < 60) begin cyc(); k++; end
    cyc();
    chk("pre_rst_cs", cs_n, 4'b1110);
    rst = 1'b1;
    #1;
    chk("arst_cs", cs_n, 4'hF);
    chk("arst_busy", busy, 0);
    chk("arst_wen", tx_wen, 0);
    for (int i = 0; i < N; i++) pq[i].delete();
    tx_wptr = '0;
    tx_rptr = '0;
    drive();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("post_rst_idle", busy, 0);
    push(1, 8'h11, 1);
    push(0, 8'h22, 1);
    drive();
    cyc();
    chk("post_rst_busy", busy, 1);
    chk("post_rst_grant", grant_id, 0);
    rd_mode = 1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
